// File: rtl/spawn_scheduler.sv
// spawn_scheduler: turns edges of the asynchronous spawn clock into lane requests (LFSR + no-triple-repeat)
// and buffers them in a first-word-fall-through FIFO. Define SPAWN_BOTH_EDGES_EN to spawn on both edges.
module spawn_scheduler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5,
  parameter int unsigned DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          spawn_clk,
  input  logic                          obs_ready,
  output logic                          obs_valid,
  output logic [1:0]                    obs_lane,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          drop_pulse,
  output logic [DROP_W-1:0]             drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [7:0]  SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  logic          sync1, sync2, edge_q, spawn_evt;
  logic [7:0]    lfsr;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    hist0, hist1;
  logic [1:0]    hist_vld;
  logic          full, push, pop, drop;
  logic [1:0]    cand, lane_next;

  // Two synchronizer flops, one edge-detect flop, then a registered event pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      edge_q    <= 1'b0;
      spawn_evt <= 1'b0;
    end else begin
      sync1  <= spawn_clk;
      sync2  <= sync1;
      edge_q <= sync2;
`ifdef SPAWN_BOTH_EDGES_EN
      spawn_evt <= sync2 ^ edge_q;
`else
      spawn_evt <= sync2 & ~edge_q;
`endif
    end
  end

  // Galois LFSR for x^8+x^6+x^5+x^4+1; free-running so lane choice depends on timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h71 : 8'h00);
  end

  always_comb begin
    full      = (fifo_count == CW'(FIFO_DEPTH));
    pop       = obs_valid && obs_ready;
    push      = spawn_evt && enable && (!full || pop);
    drop      = spawn_evt && enable && full && !pop;
    cand      = lfsr[1:0];
    lane_next = cand;
    if (hist_vld == 2'd2 && cand == hist0 && cand == hist1) lane_next = cand + 2'd1;
  end

  assign obs_valid = (fifo_count != '0);
  assign obs_lane  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hist0      <= '0;
      hist1      <= '0;
      hist_vld   <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      hist_vld   <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= lane_next;
        wr_ptr      <= wr_ptr + AW'(1);
        hist1       <= hist0;
        hist0       <= lane_next;
        if (hist_vld != 2'd2) hist_vld <= hist_vld + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      drop_pulse <= drop;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Receiving end of the spawn clock: consumes the slow toggling spawn clock from the clock divider and turns each rising edge into one obstacle spawn request.
- Lane per request chosen by an 8-bit LFSR with a no-triple-repeat rule.
- Requests buffered in a small FIFO and handed to the obstacle renderer over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, pending-request entries (power of two, 2..8)
- LFSR_SEED, 8'hA5, LFSR reset value; a value of 0 is replaced by 8'h01
- DROP_W, 8, width of saturating drop counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  game running; spawn events ignored when low
- clear  input  1  synchronous flush (new race)
- spawn_clk  input  1  slow toggling spawn clock from divider; treated as asynchronous
- obs_ready  input  1  renderer accepts head request
- obs_valid  output  1  FIFO non-empty
- obs_lane  output  2  lane (0..3) of head request
- fifo_count  output  clog2(FIFO_DEPTH)+1  entries held
- drop_pulse  output  1  one-cycle pulse when an event is lost to a full FIFO
- drop_cnt  output  DROP_W  saturating count of dropped events

Behaviour:
- Reset (async, rst_n low): all outputs 0, FIFO empty, lane history invalid, sync/edge flops 0, LFSR = LFSR_SEED.
- Input path: spawn_clk passes through a 2-flop synchronizer, then one edge-detect flop.
  - spawn_evt is a 1-cycle pulse, 3 clk edges after the first clk edge sampling spawn_clk high.
- LFSR:
  - Galois, taps x^8+x^6+x^5+x^4+1.
  - Advances every clk regardless of enable; freezes only under reset.
  - Candidate lane = lfsr[1:0] sampled on the spawn_evt cycle.
- Repeat rule:
  - If candidate equals both of the last two pushed lanes (history valid), push (candidate+1) mod 4.
  - Otherwise push the candidate.
  - History updates only on a successful push.
- Push: spawn_evt && enable && (not full || pop this cycle).
- Full with no pop:
  - Event dropped, drop_pulse=1 next cycle.
  - drop_cnt += 1, saturating at all-ones.
  - LFSR and history unaffected.
- Pop: obs_valid && obs_ready.
  - FIFO is first-word-fall-through: obs_lane is valid whenever obs_valid=1.
  - obs_lane and obs_valid must stay stable until the handshake completes.
- Simultaneous push+pop: allowed at full and at empty.
  - At empty: the pushed entry appears the next cycle, since obs_valid was 0.
  - fifo_count is unchanged when both occur.
- Latency: first request visible (obs_valid=1) 1 cycle after the spawn_evt cycle into an empty FIFO.
- clear:
  - Empties FIFO, invalidates history, zeroes drop_cnt.
  - Overrides any push/pop that cycle.
  - Does not touch the LFSR or the sync flops, so an edge in flight still produces an event after clear deasserts.
- enable low: events discarded silently (no drop_pulse); FIFO still drains via handshake.
- Reset mid-operation: immediate return to reset state; a pending handshake is abandoned.
- Pointers: wrap modulo FIFO_DEPTH.
- fifo_count: range 0..FIFO_DEPTH, never exceeds FIFO_DEPTH.

Optional Feature:
- SPAWN_BOTH_EDGES_EN defined: spawn_evt fires on both rising and falling edges of synchronized spawn_clk, doubling the spawn rate with the same divider setting. Latency is 3 cycles for either edge.
- Not defined: rising edges only; falling edges are ignored.

Test Plan:
- Reset, then one spawn_clk rise with enable=1, obs_ready=0 -> obs_valid rises exactly 4 clk after the rise is sampled; fifo_count=1; obs_lane = lfsr[1:0] from the bench model, drop_cnt=0.
- 6 rises with obs_ready=0, FIFO_DEPTH=4 -> fifo_count saturates at 4; two drop_pulse pulses; drop_cnt=2; then obs_ready=1 for 4 cycles drains all 4 entries in order, obs_valid=0 after.
- Force LFSR_SEED so three consecutive candidates are lane 2 -> pushed lanes 2,2,3.
- FIFO full with obs_ready=1 on the spawn_evt cycle -> push accepted, fifo_count stays 4, no drop_pulse.
- clear asserted with 3 entries and drop_cnt=5 -> next cycle fifo_count=0, obs_valid=0, drop_cnt=0; LFSR continues its sequence unchanged.
- rst_n low mid-handshake (obs_valid=1, obs_ready=0) -> outputs 0 asynchronously. Under SPAWN_BOTH_EDGES_EN, one full spawn_clk period yields 2 requests; without it, 1.
